// File: rtl/wb_pkg.sv
// Shared widths and queue entry type for the register-file writeback queue.
// The entry layout is fixed here so the queue and its lookup ports stay consistent.
package wb_pkg;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = 5'd31;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// One read-side lookup into the writeback queue: reports whether a queued entry
// targets ra and returns the youngest matching data.
module wb_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  wb_entry_t        entries [DEPTH],
    input  logic [PW-1:0]    head,
    input  logic [AW-1:0]    ra,
    output logic             pend,
    output logic [XLEN-1:0]  data
);

    logic [PW-1:0] w_idx;

    // Walk oldest to youngest so later matches override earlier ones.
    always_comb begin
        pend  = 1'b0;
        data  = '0;
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = head + PW'(i);
            if (entries[w_idx].valid && (entries[w_idx].addr == ra) && (ra != REG_ZERO)) begin
                pend = 1'b1;
                data = entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue_32x64.sv
// Writeback FIFO feeding the 32x64 register file write port, with two operand lookups.
// Define WB_FWD_EN to drive fwdA/fwdB with the youngest queued data; otherwise they read 0.
module wb_queue_32x64
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int AW    = 5,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_addr,
    input  logic [XLEN-1:0]  in_data,
    input  logic             hold,
    output logic             w,
    output logic [AW-1:0]    wa,
    output logic [XLEN-1:0]  wd,
    input  logic [AW-1:0]    raA,
    input  logic [AW-1:0]    raB,
    output logic             pendA,
    output logic             pendB,
    output logic [XLEN-1:0]  fwdA,
    output logic [XLEN-1:0]  fwdB,
    output logic [CW-1:0]    count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_queue_32x64: DEPTH must be a power of 2 and at least 2");
    end
    if (XLEN != wb_pkg::XLEN || AW != wb_pkg::AW) begin : g_bad_width
        $error("wb_queue_32x64: XLEN/AW must match wb_pkg");
    end

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wb_entry_t        r_entries [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    wb_entry_t        w_head_entry;
    logic             w_pend_a;
    logic             w_pend_b;
    logic [XLEN-1:0]  w_data_a;
    logic [XLEN-1:0]  w_data_b;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_CNT);
    assign w_head_entry = r_entries[r_head];

    // Writes to the zero register complete the handshake but are never stored.
    assign w_push   = in_valid && !w_full && (in_addr != REG_ZERO);
    assign w_pop    = w;

    assign in_ready = rst || !w_full;
    assign w        = !rst && !w_empty && !hold;
    assign wa       = (rst || w_empty) ? '0 : w_head_entry.addr;
    assign wd       = (rst || w_empty) ? '0 : w_head_entry.data;
    assign count    = rst ? '0 : r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_entries[r_tail] <= '{valid: 1'b1, addr: in_addr, data: in_data};
                r_tail            <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    wb_match #(.DEPTH(DEPTH), .PW(PW)) u_match_a (
        .entries (r_entries),
        .head    (r_head),
        .ra      (raA),
        .pend    (w_pend_a),
        .data    (w_data_a)
    );

    wb_match #(.DEPTH(DEPTH), .PW(PW)) u_match_b (
        .entries (r_entries),
        .head    (r_head),
        .ra      (raB),
        .pend    (w_pend_b),
        .data    (w_data_b)
    );

    assign pendA = !rst && w_pend_a;
    assign pendB = !rst && w_pend_b;

`ifdef WB_FWD_EN
    assign fwdA = rst ? '0 : w_data_a;
    assign fwdB = rst ? '0 : w_data_b;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{w_data_a, w_data_b};
    assign fwdA = '0;
    assign fwdB = '0;
`endif

endmodule
